// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch slice.
//   INSTR_W : instruction / address width
//   PC_STEP : byte distance between consecutive fetch addresses
//   ENTRY_W : width of one prefetch queue entry {pc, instr}
//   fetch_state_t : fetch controller states
package proc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int ENTRY_W = 2 * INSTR_W;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with single-cycle flush, used as the instruction prefetch queue.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empty the queue this cycle (wins over push; a same-cycle pop still
//                 completes for the consumer since it sampled head_data already)
//   push        : write push_data at the tail
//   push_data   : entry to write
//   pop         : remove the head entry (ignored when empty)
//   head_data   : entry at the head, zero when empty
//   occupancy   : number of stored entries
module fetch_queue #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (occupancy != '0);
  // Full queue can still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((occupancy != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = (occupancy != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential word fetches to instruction memory,
// buffers returned words with their addresses in a prefetch queue and handles
// branch redirects by discarding responses still in flight.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   imem_req/imem_addr        : fetch request and word-aligned byte address
//   imem_gnt                  : memory accepts the request this cycle
//   imem_rvalid/imem_rdata    : in-order read data return
//   instr_valid/instr/instr_pc: queue head toward decode
//   instr_ready               : consumer takes the head this cycle
//   redirect/redirect_pc      : restart fetching at redirect_pc (bits [1:0] ignored)
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | normal issue; requests go out while queue slots can be reserved
// FLUSH | no requests; responses for the abandoned stream are discarded
import proc_pkg::*;

module instruction_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc
);

  localparam int          CW     = $clog2(QUEUE_DEPTH) + 1;
  localparam int          OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] STEP   = 32'(PC_STEP);
  localparam logic [31:0] DEPTH_U = 32'(QUEUE_DEPTH);
  localparam logic [31:0] MAX_U  = 32'(MAX_OUTSTANDING);

  fetch_state_t       state, state_n;
  logic [INSTR_W-1:0] fetch_pc, pc_n;
  logic [OW-1:0]      outstanding, out_n;
  logic [OW-1:0]      drop_cnt, drop_n;
  logic               req_q, req_n;

  logic [CW-1:0]      occupancy, occ_n;
  logic [ENTRY_W-1:0] head_data;
  logic               grant;
  logic               rv_live;
  logic               rv_drop;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] rsp_pc;

  assign grant   = req_q && imem_gnt;
  assign rv_live = imem_rvalid && (state == FETCH) && (outstanding != '0);
  assign rv_drop = imem_rvalid && (state == FLUSH) && (drop_cnt != '0);
  assign push    = rv_live && !redirect;
  assign pop     = instr_valid && instr_ready;

  // Responses return in order, so the oldest unanswered request sits
  // 'outstanding' words behind the current fetch address.
  assign rsp_pc  = fetch_pc - (32'(outstanding) * STEP);

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    out_n   = outstanding;
    drop_n  = drop_cnt;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_n    = redirect_pc & ~32'h3;
          drop_n  = outstanding + OW'(grant) - OW'(rv_live);
          out_n   = '0;
          state_n = (drop_n != '0) ? FLUSH : FETCH;
        end else begin
          if (grant) pc_n = fetch_pc + STEP;
          out_n = outstanding + OW'(grant) - OW'(rv_live);
        end
      end
      FLUSH: begin
        if (redirect) pc_n = redirect_pc & ~32'h3;
        drop_n = drop_cnt - OW'(rv_drop);
        if (drop_n == '0) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase

    occ_n = redirect ? '0 : (occupancy + CW'(push) - CW'(pop));
    // Request only when every granted word is guaranteed a queue slot.
    req_n = (state_n == FETCH) &&
            ((32'(occ_n) + 32'(out_n)) < DEPTH_U) &&
            (32'(out_n) < MAX_U);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      req_q       <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= pc_n;
      outstanding <= out_n;
      drop_cnt    <= drop_n;
      req_q       <= req_n;
    end
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({rsp_pc, imem_rdata}),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (occupancy != '0);
  assign instr       = head_data[INSTR_W-1:0];
  assign instr_pc    = head_data[ENTRY_W-1:INSTR_W];

  // A response with nothing in flight is a memory protocol violation.
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding == '0) && (drop_cnt == '0)));

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QD       = 4;
  localparam int          MAXO     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  instruction_fetch #(
    .RESET_PC        (RESET_PC),
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- memory model + consumer + reference stream ----------------
  typedef struct {
    logic [31:0] addr;
    int          age;
    int          lat;
  } pend_t;

  pend_t       pending[$];
  int          gnt_mode   = 0;   // 0: always grant, 1: random
  int          lat_mode   = 0;   // 0: fixed lat_fix, 1: random 1..4
  int          lat_fix    = 1;
  int          ready_mode = 1;   // 0: never, 1: always, 2: random
  bit          rand_redir = 1'b0;
  bit          redir_req  = 1'b0;
  logic [31:0] redir_target = 32'h0;

  logic [31:0] exp_pc = RESET_PC;
  int          pop_cnt   = 0;
  int          grant_cnt = 0;
  logic [31:0] grant_log [64];
  int          post_cnt  = 0;
  logic [31:0] post_addr [2];
  bit          redir_pop_wait = 1'b0;
  bit          redir_pop_seen = 1'b0;
  logic [31:0] first_redir_pop = 32'h0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending.delete();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      exp_pc      = RESET_PC;
      pop_cnt     = 0;
      grant_cnt   = 0;
      post_cnt    = 0;
      prev_wait   = 1'b0;
      redir_pop_wait = 1'b0;
      redir_pop_seen = 1'b0;
    end else begin
      if (prev_wait) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      check("inflight_le_max", 32'(pending.size() <= MAXO), 32'd1);

      for (int i = 0; i < pending.size(); i++) pending[i].age++;
      if (pending.size() > 0 && pending[0].age >= pending[0].lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pending[0].addr);
        void'(pending.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end

      imem_gnt = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (ready_mode)
        0:       instr_ready = 1'b0;
        1:       instr_ready = 1'b1;
        default: instr_ready = ($urandom_range(0, 2) != 0);
      endcase

      redirect = 1'b0;
      if (redir_req) begin
        redirect    = 1'b1;
        redirect_pc = redir_target;
        redir_req   = 1'b0;
      end else if (rand_redir && $urandom_range(0, 31) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      end

      // Consumer sees the in-order stream; a pop with a redirect completes first.
      if (instr_valid && instr_ready) begin
        check("pop_pc", instr_pc, exp_pc);
        check("pop_instr", instr, mem_word(exp_pc));
        if (redir_pop_wait) begin
          first_redir_pop = instr_pc;
          redir_pop_wait  = 1'b0;
          redir_pop_seen  = 1'b1;
        end
        exp_pc = exp_pc + 32'd4;
        pop_cnt++;
      end
      if (redirect) begin
        exp_pc         = redirect_pc & ~32'h3;
        post_cnt       = 0;
        redir_pop_wait = 1'b1;
        redir_pop_seen = 1'b0;
      end

      if (imem_req && imem_gnt) begin
        pending.push_back('{addr: imem_addr, age: 0,
                            lat: (lat_mode == 0) ? lat_fix : int'($urandom_range(1, 4))});
        if (grant_cnt < 64) grant_log[grant_cnt] = imem_addr;
        grant_cnt++;
        if (!redirect && post_cnt < 2) begin
          post_addr[post_cnt] = imem_addr;
          post_cnt++;
        end
      end
      prev_wait = imem_req && !imem_gnt && !redirect;
      prev_addr = imem_addr;
    end
  end

  // ---------------- directed redirect table ----------------
  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr0;
    logic [31:0] exp_addr1;
  } redir_vec_t;

  redir_vec_t vecs [5];

  task automatic do_reset(input bit chk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (chk) begin
      check("async_rst_req", 32'(imem_req), 32'd0);
      check("async_rst_addr", imem_addr, RESET_PC);
      check("async_rst_valid", 32'(instr_valid), 32'd0);
      check("async_rst_instr", instr, 32'd0);
      check("async_rst_pc", instr_pc, 32'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic fire_redirect(input logic [31:0] t);
    @(posedge clk);
    redir_target = t;
    redir_req    = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_post(input int need, input int bound, input string name);
    int n;
    n = 0;
    while ((post_cnt < need || !redir_pop_seen) && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (n >= bound) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int base;
    int n;
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);

    // Streaming: gnt tied high, one-cycle response, consumer always ready
    gnt_mode = 0; lat_mode = 0; lat_fix = 1; ready_mode = 1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("stream_pops_ge12", 32'(pop_cnt >= 12), 32'd1);
    check("stream_first_grant", grant_log[0], RESET_PC);

    // Backpressure: queue fills with exactly QD entries, then drains
    ready_mode = 0;
    do_reset(1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("full_grants", 32'(grant_cnt), 32'(QD));
    check("full_req_low", 32'(imem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    ready_mode = 1;
    repeat (12) @(posedge clk);
    check("resume_addr", grant_log[QD], 32'h0000_0010);
    check("drain_pops", 32'(pop_cnt >= 5), 32'd1);

    // Redirect with two requests outstanding
    lat_fix = 3;
    do_reset(1'b0);
    n = 0;
    while (pending.size() != 2 && n < 30) begin
      @(posedge clk);
      n++;
    end
    check("two_outstanding_seen", 32'(n < 30), 32'd1);
    #1 check("max_out_req_low", 32'(imem_req), 32'd0);
    fire_redirect(32'h0000_0100);
    wait_post(1, 40, "flush_redirect");
    check("flush_next_addr", post_addr[0], 32'h0000_0100);
    check("flush_first_pop", first_redir_pop, 32'h0000_0100);

    // Redirects colliding with grant and response each cycle, incl. wrap
    lat_fix = 1;
    foreach (vecs[i]) begin
      repeat ($urandom_range(2, 5)) @(posedge clk);
      fire_redirect(vecs[i].target);
      wait_post(2, 40, "redir_vec");
      check("redir_addr0", post_addr[0], vecs[i].exp_addr0);
      check("redir_addr1", post_addr[1], vecs[i].exp_addr1);
      check("redir_first_pop", first_redir_pop, vecs[i].exp_addr0);
    end

    // Reset in the middle of traffic, queue partly full and requests in flight
    ready_mode = 0; lat_fix = 4;
    repeat (12) @(posedge clk);
    ready_mode = 1; lat_fix = 1;
    do_reset(1'b1);
    repeat (10) @(posedge clk);
    check("restart_grant", grant_log[0], RESET_PC);
    check("restart_pops", 32'(pop_cnt >= 3), 32'd1);

    // Randomized traffic against the reference stream
    base = pop_cnt;
    gnt_mode = 1; lat_mode = 1; ready_mode = 2; rand_redir = 1'b1;
    repeat (3000) @(posedge clk);
    rand_redir = 1'b0; ready_mode = 1;
    repeat (30) @(posedge clk);
    check("random_progress", 32'(pop_cnt - base > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002: Parameter QUEUE_DEPTH, default 4, prefetch queue entries (power of two, 2..8).
REQ-003: Parameter MAX_OUTSTANDING, default 2, granted-but-unanswered memory requests allowed.
REQ-004: One clock; reset is asynchronous and active-low (ports clk and rst_n; polarity and synchronicity fixed).
REQ-005: clk  input  1  rising-edge clock for all state.
REQ-006: rst_n  input  1  asynchronous active-low reset.
REQ-007: imem_req  output  1  fetch request valid.
REQ-008: imem_addr  output  32  fetch byte address, word aligned.
REQ-009: imem_gnt  input  1  memory accepts the request this cycle.
REQ-010: imem_rvalid  input  1  read data returned (in order, no earlier than the cycle after grant).
REQ-011: imem_rdata  input  32  instruction word.
REQ-012: instr_valid  output  1  queue head valid toward decode/execute.
REQ-013: instr  output  32  instruction word at the queue head.
REQ-014: instr_pc  output  32  address of instr.
REQ-015: instr_ready  input  1  consumer takes the head this cycle.
REQ-016: redirect  input  1  branch/jump: discard prefetched stream.
REQ-017: redirect_pc  input  32  new fetch address; bits [1:0] forced to zero.

Function
REQ-018: Request acceptance occurs when imem_req and imem_gnt are both high; imem_addr shall stay stable while imem_req is high without imem_gnt.
REQ-019: imem_req shall assert only in state FETCH when occupancy + outstanding < QUEUE_DEPTH and outstanding < MAX_OUTSTANDING; this reserves a queue slot for every granted request.
REQ-020: On each grant, fetch PC shall advance by 4 (32-bit wrap from FFFF_FFFC to 0000_0000) and outstanding shall increment.
REQ-021: Each non-discarded imem_rvalid shall push {pc, imem_rdata} into the queue and decrement outstanding; pc is the address of the matching granted request.
REQ-022: instr_valid shall equal (occupancy != 0); instr and instr_pc shall come from the head with zero added latency. Minimum latency from grant to instr_valid is one cycle after rvalid.
REQ-023: instr_valid && instr_ready shall pop the head; push and pop in the same cycle shall leave occupancy unchanged.
REQ-024: States: FETCH (normal issue), FLUSH (wait for discarded responses). Reset enters FETCH.
REQ-025: redirect in FETCH: flush the queue, load fetch PC with redirect_pc, and withdraw any ungranted request; drop count = outstanding, plus 1 if a grant occurs in the same cycle. Next state is FLUSH if drop count != 0, else FETCH.
REQ-026: In FLUSH, imem_req shall be 0, and every rvalid shall be discarded and decrement the drop count. At zero the block shall return to FETCH and issue at the redirect target the following cycle.
REQ-027: redirect in FLUSH shall reload fetch PC with the new redirect_pc and keep the current drop count.
REQ-028: rvalid coinciding with redirect shall be discarded and counted against the drop count.
REQ-029: A pop coinciding with redirect completes for the consumer; the queue is then empty.
REQ-030: rvalid with outstanding == 0 and drop count == 0 is a protocol error; it shall be ignored and flagged by an assertion.

Reset
REQ-031: While rst_n is low: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0, occupancy = outstanding = drop count = 0, state FETCH.
REQ-032: Reset mid-operation shall abandon all in-flight requests; the memory is reset by the same rst_n. The first request at RESET_PC may assert in the first cycle after rst_n rises.

Structure
REQ-033: Package proc_pkg shall hold INSTR_W = 32, PC_STEP = 4, and the fetch state enum {FETCH, FLUSH}.
REQ-034: The queue shall be a sub-module fetch_queue (synchronous FIFO with flush, width 64, depth QUEUE_DEPTH, occupancy output).

Verification
REQ-035: Reset release, gnt tied 1, rvalid one cycle after each grant, ready 1 -> instr_pc 0, 4, 8, ... in order, with instr matching memory at each.
REQ-036: ready held 0 -> exactly 4 entries fill, imem_req drops and no further grants occur; ready then 1 -> 4 consecutive pops, after which fetch resumes at 0x10.
REQ-037: redirect to 0x100 with 2 outstanding -> FLUSH, the 2 responses are dropped, and the next imem_addr is 0x100; the first delivered instr_pc is 0x100.
REQ-038: redirect coinciding with a grant and an rvalid -> drop count is correct and no stale instruction appears at instr_pc.
REQ-039: Fetch PC at 0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-040: rst_n asserted with the queue full and 2 outstanding -> all outputs take their reset values immediately (asynchronously), and fetch restarts at RESET_PC.
